tconv2: RTL and testbench

TCONV2 -- requirements
Module: tconv2

---
 rtl/tconv2.sv | 194 +++++++++++++++++++
 tb/tb_tconv2.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tconv2.sv
// -----------------------------------------------------------------------------
// tconv2 -- stride-1 2-D transposed convolution engine.
//
// A start pulse in IDLE captures the input feature map and the kernel. The
// block then clears its accumulators and scatters one input pixel per cycle,
// row-major. Every pixel adds SIZEKer*SIZEKer products in parallel into the
// (SIZE+SIZEKer-1)^2 accumulator grid. A final WRITE cycle loads
// tconvOut = narrow(acc >>> 4) and pulses done.
//
// Start-to-done latency is SIZE*SIZE+2 cycles.
//
// Parameters:
//   SIZE      input feature-map edge length
//   SIZEKer   kernel edge length
//   WIDTH_BIT signed element width of the input, the kernel and the output
//
// Ports:
//   clock       rising-edge clock
//   nreset      asynchronous active-low reset
//   start       operation request, sampled only in IDLE
//   inpMatrixI  input feature map [SIZE][SIZE]
//   kerMatrix   kernel weights [SIZEKer][SIZEKer]
//   busy        high from the capture edge until the WRITE edge
//   done        one-cycle pulse when tconvOut is updated
//   tconvOut    result [SIZE+SIZEKer-1][SIZE+SIZEKer-1]; holds between results
//
// Build option:
//   TCONV2_SAT_EN  when defined, the shifted result saturates to the signed
//                  WIDTH_BIT range. Otherwise it wraps to the low WIDTH_BIT
//                  bits.
// -----------------------------------------------------------------------------
module tconv2 #(
    parameter int SIZE      = 5,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 8
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic                        start,
    input  logic signed [WIDTH_BIT-1:0] inpMatrixI [SIZE][SIZE],
    input  logic signed [WIDTH_BIT-1:0] kerMatrix  [SIZEKer][SIZEKer],
    output logic                        busy,
    output logic                        done,
    output logic signed [WIDTH_BIT-1:0] tconvOut   [SIZE+SIZEKer-1][SIZE+SIZEKer-1]
);

    localparam int OUT_SIZE    = SIZE + SIZEKer - 1;
    localparam int ACC_W       = 2 * WIDTH_BIT + 4;
    localparam int IDX_W       = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int OIDX_W      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int unsigned FRAC_SHIFT = 32'd4;

`ifdef TCONV2_SAT_EN
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((64'sd1 <<< (WIDTH_BIT - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        SCATTER = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t                      state_r;
    logic [IDX_W-1:0]            i_r;
    logic [IDX_W-1:0]            j_r;
    logic signed [WIDTH_BIT-1:0] x_r   [SIZE][SIZE];
    logic signed [WIDTH_BIT-1:0] k_r   [SIZEKer][SIZEKer];
    logic signed [ACC_W-1:0]     acc_r [OUT_SIZE][OUT_SIZE];

    logic signed [WIDTH_BIT-1:0] x_cur_s;
    logic [OIDX_W-1:0]           row_idx_s [SIZEKer];
    logic [OIDX_W-1:0]           col_idx_s [SIZEKer];
    logic signed [ACC_W-1:0]     prod_s    [SIZEKer][SIZEKer];

    // Shift the accumulator right with floor rounding, then narrow it to WIDTH_BIT.
    function automatic logic signed [WIDTH_BIT-1:0] narrow(input logic signed [ACC_W-1:0] acc);
`ifdef TCONV2_SAT_EN
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> FRAC_SHIFT;
        if (sh > MAX_V) begin
            narrow = MAX_V[WIDTH_BIT-1:0];
        end else if (sh < MIN_V) begin
            narrow = MIN_V[WIDTH_BIT-1:0];
        end else begin
            narrow = sh[WIDTH_BIT-1:0];
        end
`else
        narrow = WIDTH_BIT'(acc >>> FRAC_SHIFT);
`endif
    endfunction

    // Compute the current pixel, its scatter target coordinates and the parallel products.
    always_comb begin
        x_cur_s = x_r[i_r][j_r];
        for (int u = 0; u < SIZEKer; u++) begin
            row_idx_s[u] = OIDX_W'(i_r) + OIDX_W'(u);
            col_idx_s[u] = OIDX_W'(j_r) + OIDX_W'(u);
        end
        for (int u = 0; u < SIZEKer; u++) begin
            for (int v = 0; v < SIZEKer; v++) begin
                prod_s[u][v] = ACC_W'(x_cur_s) * ACC_W'(k_r[u][v]);
            end
        end
    end

    // Control FSM, operand capture, accumulation and registered outputs.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            i_r     <= '0;
            j_r     <= '0;
            for (int a = 0; a < SIZE; a++) begin
                for (int b = 0; b < SIZE; b++) begin
                    x_r[a][b] <= '0;
                end
            end
            for (int a = 0; a < SIZEKer; a++) begin
                for (int b = 0; b < SIZEKer; b++) begin
                    k_r[a][b] <= '0;
                end
            end
            for (int a = 0; a < OUT_SIZE; a++) begin
                for (int b = 0; b < OUT_SIZE; b++) begin
                    acc_r[a][b]    <= '0;
                    tconvOut[a][b] <= '0;
                end
            end
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_r     <= inpMatrixI;
                        k_r     <= kerMatrix;
                        busy    <= 1'b1;
                        state_r <= CLEAR;
                    end
                end
                CLEAR: begin
                    done <= 1'b0;
                    i_r  <= '0;
                    j_r  <= '0;
                    for (int a = 0; a < OUT_SIZE; a++) begin
                        for (int b = 0; b < OUT_SIZE; b++) begin
                            acc_r[a][b] <= '0;
                        end
                    end
                    state_r <= SCATTER;
                end
                SCATTER: begin
                    done <= 1'b0;
                    // Each (u,v) lands on a distinct accumulator, so the writes never collide.
                    for (int u = 0; u < SIZEKer; u++) begin
                        for (int v = 0; v < SIZEKer; v++) begin
                            acc_r[row_idx_s[u]][col_idx_s[v]] <=
                                acc_r[row_idx_s[u]][col_idx_s[v]] + prod_s[u][v];
                        end
                    end
                    if (j_r == IDX_W'(SIZE - 1)) begin
                        j_r <= '0;
                        if (i_r == IDX_W'(SIZE - 1)) begin
                            i_r     <= '0;
                            state_r <= WRITE;
                        end else begin
                            i_r <= i_r + IDX_W'(1);
                        end
                    end else begin
                        j_r <= j_r + IDX_W'(1);
                    end
                end
                WRITE: begin
                    for (int a = 0; a < OUT_SIZE; a++) begin
                        for (int b = 0; b < OUT_SIZE; b++) begin
                            tconvOut[a][b] <= narrow(acc_r[a][b]);
                        end
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tconv2.sv
// -----------------------------------------------------------------------------
// tb_tconv2 -- scoreboard testbench for tconv2 at its default sizes (5, 3, 8).
//
// The stimulus issues directed operations and pushes onto queues the expected
// result matrix and the expected done cycle. A separate monitor pops one entry
// per done pulse and compares the matrix and the cycle. Directed spot values
// are also checked after each operation.
// -----------------------------------------------------------------------------
module tb_tconv2;

    localparam int SIZE = 5;
    localparam int KS   = 3;
    localparam int W    = 8;
    localparam int OUT  = SIZE + KS - 1;
    localparam int LAT  = SIZE * SIZE + 2;

    logic                clock = 1'b0;
    logic                nreset;
    logic                start;
    logic signed [W-1:0] x_m   [SIZE][SIZE];
    logic signed [W-1:0] k_m   [KS][KS];
    logic                busy;
    logic                done;
    logic signed [W-1:0] out_s [OUT][OUT];

    tconv2 #(.SIZE(SIZE), .SIZEKer(KS), .WIDTH_BIT(W)) dut (
        .clock      (clock),
        .nreset     (nreset),
        .start      (start),
        .inpMatrixI (x_m),
        .kerMatrix  (k_m),
        .busy       (busy),
        .done       (done),
        .tconvOut   (out_s)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int done_cnt = 0;

    logic [OUT*OUT*W-1:0] exp_mat_q [$];
    int                   exp_cyc_q [$];
    string                exp_name_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: direct gather form of the transposed convolution.
    task automatic push_expected(input string name, input int exp_cyc);
        logic [OUT*OUT*W-1:0] m;
        longint acc, sh;
        logic [W-1:0] b;
        for (int p = 0; p < OUT; p++) begin
            for (int q = 0; q < OUT; q++) begin
                acc = 0;
                for (int u = 0; u < KS; u++) begin
                    for (int v = 0; v < KS; v++) begin
                        if (p - u >= 0 && p - u < SIZE && q - v >= 0 && q - v < SIZE)
                            acc += longint'(x_m[p-u][q-v]) * longint'(k_m[u][v]);
                    end
                end
                sh = acc >>> 4;
`ifdef TCONV2_SAT_EN
                if (sh > 127) sh = 127;
                else if (sh < -128) sh = -128;
`endif
                b = sh[W-1:0];
                m[(p*OUT+q)*W +: W] = b;
            end
        end
        exp_mat_q.push_back(m);
        exp_cyc_q.push_back(exp_cyc);
        exp_name_q.push_back(name);
    endtask

    // Monitor: every done pulse must match the oldest scoreboard entry.
    always @(negedge clock) begin
        if (nreset === 1'b1 && done === 1'b1) begin
            logic [OUT*OUT*W-1:0] m;
            logic signed [W-1:0]  e;
            int    ec, nmis;
            string nm;
            done_cnt++;
            if (exp_mat_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                m  = exp_mat_q.pop_front();
                ec = exp_cyc_q.pop_front();
                nm = exp_name_q.pop_front();
                chk({nm, "_done_cycle"}, cyc, ec);
                nmis = 0;
                for (int p = 0; p < OUT; p++) begin
                    for (int q = 0; q < OUT; q++) begin
                        e = m[(p*OUT+q)*W +: W];
                        if (out_s[p][q] !== e) begin
                            if (nmis == 0)
                                $display("  first diff %s [%0d][%0d] got %0d exp %0d",
                                         nm, p, q, out_s[p][q], e);
                            nmis++;
                        end
                    end
                end
                chk({nm, "_matrix_mismatches"}, nmis, 0);
            end
        end
    end

    task automatic fill(input int xv, input int kv);
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) x_m[i][j] = W'(xv);
        for (int u = 0; u < KS; u++)
            for (int v = 0; v < KS; v++) k_m[u][v] = W'(kv);
    endtask

    task automatic check_zero_out(input string name);
        int nz = 0;
        for (int p = 0; p < OUT; p++)
            for (int q = 0; q < OUT; q++)
                if (out_s[p][q] !== 8'sd0) nz++;
        chk(name, nz, 0);
    endtask

    // Caller is at a negedge: start is raised, the capture edge passes, start drops.
    task automatic launch(input string name, output int cap);
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cap   = cyc;
        start = 1'b0;
        chk({name, "_busy_after_start"}, busy, 1);
        push_expected(name, cap + LAT);
    endtask

    task automatic wait_drain(input string name);
        for (int t = 0; t < 200 && exp_mat_q.size() > 0; t++) @(negedge clock);
        chk({name, "_pending_after_timeout"}, exp_mat_q.size(), 0);
        @(negedge clock);
        chk({name, "_done_single_cycle"}, done, 0);
        chk({name, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        int cap, d0;
        nreset = 1'b0;
        start  = 1'b0;
        fill(0, 0);
        repeat (3) @(negedge clock);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        check_zero_out("reset_out_nonzero");

        // Impulse, started on the release edge itself.
        x_m[0][0] = 8'sd16;
        for (int u = 0; u < KS; u++)
            for (int v = 0; v < KS; v++) k_m[u][v] = W'(3*u + v + 1);
        nreset = 1'b1;
        launch("impulse", cap);
        wait_drain("impulse");
        chk("impulse_00", out_s[0][0], 1);
        chk("impulse_12", out_s[1][2], 6);
        chk("impulse_22", out_s[2][2], 9);
        chk("impulse_33", out_s[3][3], 0);

        // Uniform.
        fill(16, 1);
        launch("uniform", cap);
        wait_drain("uniform");
        chk("uniform_33", out_s[3][3], 9);
        chk("uniform_00", out_s[0][0], 1);
        chk("uniform_03", out_s[0][3], 3);
        chk("uniform_30", out_s[3][0], 3);
        chk("uniform_66", out_s[6][6], 1);

        // Positive overflow.
        fill(127, 127);
        launch("ovf_pos", cap);
        wait_drain("ovf_pos");
`ifdef TCONV2_SAT_EN
        chk("ovf_pos_center", out_s[3][3], 127);
`else
        chk("ovf_pos_center", out_s[3][3], 112);
`endif

        // Negative overflow: center acc = -146304, shifted to -9144.
        fill(-128, 127);
        launch("ovf_neg", cap);
        wait_drain("ovf_neg");
`ifdef TCONV2_SAT_EN
        chk("ovf_neg_center", out_s[3][3], -128);
`else
        chk("ovf_neg_center", out_s[3][3], 72);
`endif

        // Floor rounding of a small negative value.
        fill(0, 0);
        x_m[0][0] = -8'sd1;
        k_m[0][0] = 8'sd1;
        launch("round", cap);
        wait_drain("round");
        chk("round_00", out_s[0][0], -1);
        chk("round_01", out_s[0][1], 0);
        chk("round_66", out_s[6][6], 0);

        // Start mid-SCATTER with scrambled inputs is ignored.
        fill(16, 1);
        d0 = done_cnt;
        launch("ignore", cap);
        fill(5, -7);
        while (cyc < cap + 12) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_drain("ignore");
        repeat (35) @(negedge clock);
        chk("ignore_done_count", done_cnt - d0, 1);

        // Start held high: the second operation begins right after done.
        fill(0, 0);
        x_m[0][0] = 8'sd16;
        k_m[1][1] = 8'sd5;
        d0 = done_cnt;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cap = cyc;
        push_expected("held1", cap + LAT);
        for (int i = 0; i < SIZE; i++)
            for (int j = 0; j < SIZE; j++) x_m[i][j] = W'(i*5 + j - 12);
        for (int u = 0; u < KS; u++)
            for (int v = 0; v < KS; v++) k_m[u][v] = W'(u - v + 16);
        push_expected("held2", cap + 2*LAT + 1);
        while (cyc < cap + LAT + 1) @(negedge clock);
        start = 1'b0;
        wait_drain("held");
        chk("held_done_count", done_cnt - d0, 2);

        // Reset mid-operation aborts with no pulse and a cleared result.
        fill(16, 1);
        d0 = done_cnt;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        cap   = cyc;
        start = 1'b0;
        while (cyc < cap + 10) @(negedge clock);
        nreset = 1'b0;
        #1;
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        check_zero_out("midreset_out_nonzero");
        repeat (2) @(negedge clock);
        nreset = 1'b1;
        repeat (40) @(negedge clock);
        chk("midreset_no_done", done_cnt - d0, 0);
        check_zero_out("midreset_out_after_release");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
